// File: rtl/punc_control_if.sv
// Control/status bundle between the PUnC control unit (master) and the datapath (slave).
// The master drives every strobe and select; the datapath supplies IR and register-file write data.
interface punc_control_if;
  logic [15:0] ir;
  logic [15:0] cc_data;
  logic        mem_w_en;
  logic [1:0]  mem_r_addr_sel;
  logic [1:0]  mem_w_addr_sel;
  logic        temp_ld;
  logic        rf_w_en;
  logic        rf_w_addr_sel;
  logic [1:0]  rf_w_data_sel;
  logic        rf_r0_addr_sel;
  logic        rf_r1_addr_sel;
  logic [1:0]  alu_sel;
  logic        alu_imm;
  logic        ir_ld;
  logic        pc_ld;
  logic        pc_inc;
  logic        pc_clr;
  logic [1:0]  pc_ld_data_sel;
  logic [2:0]  nzp;
  logic        halted;
  logic [2:0]  state_dbg;

  modport master (
    input  ir, cc_data,
    output mem_w_en, mem_r_addr_sel, mem_w_addr_sel, temp_ld,
    output rf_w_en, rf_w_addr_sel, rf_w_data_sel, rf_r0_addr_sel, rf_r1_addr_sel,
    output alu_sel, alu_imm, ir_ld, pc_ld, pc_inc, pc_clr, pc_ld_data_sel,
    output nzp, halted, state_dbg
  );

  modport slave (
    output ir, cc_data,
    input  mem_w_en, mem_r_addr_sel, mem_w_addr_sel, temp_ld,
    input  rf_w_en, rf_w_addr_sel, rf_w_data_sel, rf_r0_addr_sel, rf_r1_addr_sel,
    input  alu_sel, alu_imm, ir_ld, pc_ld, pc_inc, pc_clr, pc_ld_data_sel,
    input  nzp, halted, state_dbg
  );
endinterface

// File: rtl/punc_control.sv
// PUnC LC3 control unit: sequences FETCH/DECODE/EXEC(/EXEC2), decodes the IR into
// datapath strobes combinationally, and owns the N/Z/P condition-code register.
module punc_control (
  input  logic              clk,
  input  logic              rst,
  punc_control_if.master    bus
);

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_EXEC2  = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  // One-hot N/Z/P classification of a register-file write value.
  function automatic logic [2:0] cc_from_data(input logic [15:0] d);
    logic [2:0] r;
    if (d[15]) begin
      r = 3'b100;
    end else if (d == 16'h0000) begin
      r = 3'b010;
    end else begin
      r = 3'b001;
    end
    return r;
  endfunction

  // Opcodes whose register write also refreshes the condition codes (JSR's R7 write does not).
  function automatic logic sets_cc(input logic [3:0] op);
    logic r;
    case (op)
      OP_ADD, OP_AND, OP_NOT, OP_LD, OP_LDR, OP_LDI, OP_LEA: r = 1'b1;
      default:                                              r = 1'b0;
    endcase
    return r;
  endfunction

  state_t      state_r;
  logic [2:0]  nzp_r;

  logic [3:0]  opcode_s;
  logic        br_taken_s;
  logic        cc_upd_s;
  logic        unused_ir_s;

  logic        mem_w_en_s;
  logic [1:0]  mem_r_addr_sel_s;
  logic [1:0]  mem_w_addr_sel_s;
  logic        temp_ld_s;
  logic        rf_w_en_s;
  logic        rf_w_addr_sel_s;
  logic [1:0]  rf_w_data_sel_s;
  logic        rf_r0_addr_sel_s;
  logic        rf_r1_addr_sel_s;
  logic [1:0]  alu_sel_s;
  logic        alu_imm_s;
  logic        ir_ld_s;
  logic        pc_ld_s;
  logic        pc_inc_s;
  logic        pc_clr_s;
  logic [1:0]  pc_ld_data_sel_s;
  logic        halted_s;

  assign opcode_s    = bus.ir[15:12];
  assign br_taken_s  = |(bus.ir[11:9] & nzp_r);
  assign unused_ir_s = ^{bus.ir[8:6], bus.ir[4:0]};

  // Decode state and opcode into datapath strobes and selects.
  always_comb begin
    mem_w_en_s       = 1'b0;
    mem_r_addr_sel_s = 2'd0;
    mem_w_addr_sel_s = 2'd0;
    temp_ld_s        = 1'b0;
    rf_w_en_s        = 1'b0;
    rf_w_addr_sel_s  = 1'b0;
    rf_w_data_sel_s  = 2'd0;
    rf_r0_addr_sel_s = 1'b0;
    rf_r1_addr_sel_s = 1'b0;
    alu_sel_s        = 2'd0;
    alu_imm_s        = 1'b0;
    ir_ld_s          = 1'b0;
    pc_ld_s          = 1'b0;
    pc_inc_s         = 1'b0;
    pc_clr_s         = 1'b0;
    pc_ld_data_sel_s = 2'd0;
    halted_s         = 1'b0;
    case (state_r)
      ST_INIT: begin
        pc_clr_s = 1'b1;
      end
      ST_FETCH: begin
        mem_r_addr_sel_s = 2'd0;
        ir_ld_s          = 1'b1;
        pc_inc_s         = 1'b1;
      end
      ST_DECODE: begin
        halted_s = 1'b0;
      end
      ST_EXEC: begin
        case (opcode_s)
          OP_ADD, OP_AND: begin
            rf_w_en_s       = 1'b1;
            rf_w_data_sel_s = 2'd0;
            alu_sel_s       = (opcode_s == OP_AND) ? 2'd1 : 2'd0;
            alu_imm_s       = bus.ir[5];
          end
          OP_NOT: begin
            rf_w_en_s = 1'b1;
            alu_sel_s = 2'd2;
          end
          OP_LD: begin
            mem_r_addr_sel_s = 2'd1;
            rf_w_en_s        = 1'b1;
            rf_w_data_sel_s  = 2'd1;
          end
          OP_LDR: begin
            mem_r_addr_sel_s = 2'd2;
            rf_w_en_s        = 1'b1;
            rf_w_data_sel_s  = 2'd1;
          end
          OP_LEA: begin
            rf_w_en_s       = 1'b1;
            rf_w_data_sel_s = 2'd3;
          end
          OP_ST: begin
            mem_w_en_s       = 1'b1;
            mem_w_addr_sel_s = 2'd0;
            rf_r1_addr_sel_s = 1'b1;
          end
          OP_STR: begin
            mem_w_en_s       = 1'b1;
            mem_w_addr_sel_s = 2'd1;
            rf_r1_addr_sel_s = 1'b1;
          end
          OP_LDI, OP_STI: begin
            mem_r_addr_sel_s = 2'd1;
            temp_ld_s        = 1'b1;
          end
          OP_BR: begin
            if (br_taken_s) begin
              pc_ld_s          = 1'b1;
              pc_ld_data_sel_s = 2'd0;
            end else begin
              pc_ld_s          = 1'b0;
            end
          end
          OP_JMP: begin
            pc_ld_s          = 1'b1;
            pc_ld_data_sel_s = 2'd1;
          end
          OP_JSR: begin
            // R7 and PC both sample the pre-edge PC, so JSRR R7 returns through the old R7.
            rf_w_en_s        = 1'b1;
            rf_w_addr_sel_s  = 1'b1;
            rf_w_data_sel_s  = 2'd2;
            pc_ld_s          = 1'b1;
            pc_ld_data_sel_s = bus.ir[11] ? 2'd2 : 2'd1;
          end
          default: begin
            pc_ld_s = 1'b0;
          end
        endcase
      end
      ST_EXEC2: begin
        case (opcode_s)
          OP_LDI: begin
            mem_r_addr_sel_s = 2'd3;
            rf_w_en_s        = 1'b1;
            rf_w_data_sel_s  = 2'd1;
          end
          OP_STI: begin
            mem_w_en_s       = 1'b1;
            mem_w_addr_sel_s = 2'd2;
            rf_r1_addr_sel_s = 1'b1;
          end
          default: begin
            mem_w_en_s = 1'b0;
          end
        endcase
      end
      ST_HALT: begin
        halted_s = 1'b1;
      end
      default: begin
        pc_clr_s = 1'b1;
      end
    endcase
  end

  assign cc_upd_s = ((state_r == ST_EXEC) || (state_r == ST_EXEC2)) &&
                    rf_w_en_s && sets_cc(opcode_s);

  // Instruction sequencer and condition-code register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_INIT;
      nzp_r   <= 3'b010;
    end else begin
      case (state_r)
        ST_INIT:   state_r <= ST_FETCH;
        ST_FETCH:  state_r <= ST_DECODE;
        ST_DECODE: state_r <= (opcode_s == OP_TRAP) ? ST_HALT : ST_EXEC;
        ST_EXEC:   state_r <= ((opcode_s == OP_LDI) || (opcode_s == OP_STI)) ? ST_EXEC2 : ST_FETCH;
        ST_EXEC2:  state_r <= ST_FETCH;
        ST_HALT:   state_r <= ST_HALT;
        default:   state_r <= ST_INIT;
      endcase
      if (cc_upd_s) begin
        nzp_r <= cc_from_data(bus.cc_data);
      end
    end
  end

  assign bus.mem_w_en       = mem_w_en_s;
  assign bus.mem_r_addr_sel = mem_r_addr_sel_s;
  assign bus.mem_w_addr_sel = mem_w_addr_sel_s;
  assign bus.temp_ld        = temp_ld_s;
  assign bus.rf_w_en        = rf_w_en_s;
  assign bus.rf_w_addr_sel  = rf_w_addr_sel_s;
  assign bus.rf_w_data_sel  = rf_w_data_sel_s;
  assign bus.rf_r0_addr_sel = rf_r0_addr_sel_s;
  assign bus.rf_r1_addr_sel = rf_r1_addr_sel_s;
  assign bus.alu_sel        = alu_sel_s;
  assign bus.alu_imm        = alu_imm_s;
  assign bus.ir_ld          = ir_ld_s;
  assign bus.pc_ld          = pc_ld_s;
  assign bus.pc_inc         = pc_inc_s;
  assign bus.pc_clr         = pc_clr_s;
  assign bus.pc_ld_data_sel = pc_ld_data_sel_s;
  assign bus.nzp            = nzp_r;
  assign bus.halted         = halted_s;
  assign bus.state_dbg      = state_r;

endmodule

// File: tb/tb_punc_control.sv
// Scoreboard bench for punc_control: per-cycle expected records are queued as each
// instruction is issued, then popped and compared while the control unit steps through it.
module tb_punc_control;

  typedef struct packed {
    logic       mem_w_en;
    logic [1:0] mem_r_addr_sel;
    logic [1:0] mem_w_addr_sel;
    logic       temp_ld;
    logic       rf_w_en;
    logic       rf_w_addr_sel;
    logic [1:0] rf_w_data_sel;
    logic       rf_r0_addr_sel;
    logic       rf_r1_addr_sel;
    logic [1:0] alu_sel;
    logic       alu_imm;
    logic       ir_ld;
    logic       pc_ld;
    logic       pc_inc;
    logic       pc_clr;
    logic [1:0] pc_ld_data_sel;
  } ctl_t;

  typedef struct {
    logic [15:0] ir;
    logic [15:0] cc;
    logic [2:0]  state;
    ctl_t        ctl;
    logic [2:0]  nzp;
    logic        halted;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  punc_control_if bus ();
  punc_control dut (.clk(clk), .rst(rst), .bus(bus));

  ctl_t obs_ctl;
  assign obs_ctl = {bus.mem_w_en, bus.mem_r_addr_sel, bus.mem_w_addr_sel, bus.temp_ld,
                    bus.rf_w_en, bus.rf_w_addr_sel, bus.rf_w_data_sel, bus.rf_r0_addr_sel,
                    bus.rf_r1_addr_sel, bus.alu_sel, bus.alu_imm, bus.ir_ld, bus.pc_ld,
                    bus.pc_inc, bus.pc_clr, bus.pc_ld_data_sel};

  rec_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  logic [2:0] exp_nzp;

  function automatic logic [2:0] nzp_of(input logic [15:0] d);
    if (d[15]) return 3'b100;
    if (d == 16'h0000) return 3'b010;
    return 3'b001;
  endfunction

  function automatic ctl_t fetch_c();
    ctl_t c = '0;
    c.ir_ld = 1'b1; c.pc_inc = 1'b1;
    return c;
  endfunction

  function automatic ctl_t init_c();
    ctl_t c = '0;
    c.pc_clr = 1'b1;
    return c;
  endfunction

  task automatic push_rec(input logic [15:0] i, input logic [15:0] c, input logic [2:0] st,
                          input ctl_t k, input logic h);
    rec_t r;
    r.ir = i; r.cc = c; r.state = st; r.ctl = k; r.nzp = exp_nzp; r.halted = h;
    sb.push_back(r);
  endtask

  // FETCH, DECODE, EXEC (and EXEC2) records; the nzp model advances after the writing cycle.
  task automatic push_instr(input logic [15:0] i, input logic [15:0] c, input ctl_t e1,
                            input ctl_t e2, input bit two, input bit upd);
    push_rec(i, c, 3'd1, fetch_c(), 1'b0);
    push_rec(i, c, 3'd2, '0, 1'b0);
    push_rec(i, c, 3'd3, e1, 1'b0);
    if (two) push_rec(i, c, 3'd4, e2, 1'b0);
    if (upd) exp_nzp = nzp_of(c);
  endtask

  task automatic test_reset();
    rec_t r;
    #1;
    checks++; if (bus.state_dbg !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d want=0", bus.state_dbg); end
    checks++; if (obs_ctl !== init_c()) begin failures++; $display("FAIL reset_ctl got=%h want=%h", obs_ctl, init_c()); end
    checks++; if (bus.nzp !== 3'b010) begin failures++; $display("FAIL reset_nzp got=%b want=010", bus.nzp); end
    checks++; if (bus.halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b want=0", bus.halted); end
    @(negedge clk);
    rst = 1'b0;
    exp_nzp = 3'b010;
    push_rec(16'h8000, 16'h0000, 3'd0, init_c(), 1'b0);
    push_instr(16'h8000, 16'h0000, '0, '0, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      r = sb.pop_front(); bus.ir = r.ir; bus.cc_data = r.cc; #1;
      checks++; if (bus.state_dbg !== r.state) begin failures++; $display("FAIL startup state got=%0d want=%0d", bus.state_dbg, r.state); end
      checks++; if (obs_ctl !== r.ctl) begin failures++; $display("FAIL startup ctl st=%0d got=%h want=%h", r.state, obs_ctl, r.ctl); end
      checks++; if (bus.nzp !== r.nzp) begin failures++; $display("FAIL startup nzp st=%0d got=%b want=%b", r.state, bus.nzp, r.nzp); end
      checks++; if (bus.halted !== r.halted) begin failures++; $display("FAIL startup halted got=%b want=%b", bus.halted, r.halted); end
      @(negedge clk);
    end
  endtask

  task automatic test_alu();
    rec_t r; ctl_t e;
    e = '0; e.rf_w_en = 1'b1; e.alu_imm = 1'b1;
    push_instr(16'h1261, 16'h0001, e, '0, 1'b0, 1'b1);
    e = '0; e.rf_w_en = 1'b1; e.alu_sel = 2'd2;
    push_instr(16'h907F, 16'h0000, e, '0, 1'b0, 1'b1);
    e = '0; e.rf_w_en = 1'b1;
    push_instr(16'h1042, 16'h8000, e, '0, 1'b0, 1'b1);
    while (sb.size() > 0) begin
      r = sb.pop_front(); bus.ir = r.ir; bus.cc_data = r.cc; #1;
      checks++; if (bus.state_dbg !== r.state) begin failures++; $display("FAIL alu state ir=%h got=%0d want=%0d", r.ir, bus.state_dbg, r.state); end
      checks++; if (obs_ctl !== r.ctl) begin failures++; $display("FAIL alu ctl ir=%h st=%0d got=%h want=%h", r.ir, r.state, obs_ctl, r.ctl); end
      checks++; if (bus.nzp !== r.nzp) begin failures++; $display("FAIL alu nzp ir=%h got=%b want=%b", r.ir, bus.nzp, r.nzp); end
      checks++; if (bus.halted !== r.halted) begin failures++; $display("FAIL alu halted got=%b want=%b", bus.halted, r.halted); end
      @(negedge clk);
    end
  endtask

  task automatic test_mem();
    rec_t r; ctl_t e;
    e = '0; e.mem_r_addr_sel = 2'd1; e.rf_w_en = 1'b1; e.rf_w_data_sel = 2'd1;
    push_instr(16'h2005, 16'h0003, e, '0, 1'b0, 1'b1);
    e = '0; e.mem_r_addr_sel = 2'd2; e.rf_w_en = 1'b1; e.rf_w_data_sel = 2'd1;
    push_instr(16'h6042, 16'h0000, e, '0, 1'b0, 1'b1);
    e = '0; e.rf_w_en = 1'b1; e.rf_w_data_sel = 2'd3;
    push_instr(16'hE003, 16'hFFFF, e, '0, 1'b0, 1'b1);
    e = '0; e.mem_w_en = 1'b1; e.mem_w_addr_sel = 2'd0; e.rf_r1_addr_sel = 1'b1;
    push_instr(16'h3005, 16'h0000, e, '0, 1'b0, 1'b0);
    e = '0; e.mem_w_en = 1'b1; e.mem_w_addr_sel = 2'd1; e.rf_r1_addr_sel = 1'b1;
    push_instr(16'h7042, 16'h0001, e, '0, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      r = sb.pop_front(); bus.ir = r.ir; bus.cc_data = r.cc; #1;
      checks++; if (bus.state_dbg !== r.state) begin failures++; $display("FAIL mem state ir=%h got=%0d want=%0d", r.ir, bus.state_dbg, r.state); end
      checks++; if (obs_ctl !== r.ctl) begin failures++; $display("FAIL mem ctl ir=%h st=%0d got=%h want=%h", r.ir, r.state, obs_ctl, r.ctl); end
      checks++; if (bus.nzp !== r.nzp) begin failures++; $display("FAIL mem nzp ir=%h got=%b want=%b", r.ir, bus.nzp, r.nzp); end
      checks++; if (bus.halted !== r.halted) begin failures++; $display("FAIL mem halted got=%b want=%b", bus.halted, r.halted); end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    rec_t r; ctl_t e, tk;
    tk = '0; tk.pc_ld = 1'b1; tk.pc_ld_data_sel = 2'd0;
    e = '0; e.rf_w_en = 1'b1; e.alu_sel = 2'd1; e.alu_imm = 1'b1;
    push_instr(16'h5020, 16'h8000, e, '0, 1'b0, 1'b1);
    push_instr(16'h0805, 16'h0000, tk, '0, 1'b0, 1'b0);
    e = '0; e.rf_w_en = 1'b1; e.alu_imm = 1'b1;
    push_instr(16'h1261, 16'h0001, e, '0, 1'b0, 1'b1);
    push_instr(16'h0805, 16'h0000, '0, '0, 1'b0, 1'b0);
    push_instr(16'h0000, 16'h0000, '0, '0, 1'b0, 1'b0);
    push_instr(16'h0E00, 16'h0000, tk, '0, 1'b0, 1'b0);
    push_instr(16'h0601, 16'h0000, tk, '0, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      r = sb.pop_front(); bus.ir = r.ir; bus.cc_data = r.cc; #1;
      checks++; if (bus.state_dbg !== r.state) begin failures++; $display("FAIL branch state ir=%h got=%0d want=%0d", r.ir, bus.state_dbg, r.state); end
      checks++; if (obs_ctl !== r.ctl) begin failures++; $display("FAIL branch ctl ir=%h st=%0d got=%h want=%h", r.ir, r.state, obs_ctl, r.ctl); end
      checks++; if (bus.nzp !== r.nzp) begin failures++; $display("FAIL branch nzp ir=%h got=%b want=%b", r.ir, bus.nzp, r.nzp); end
      checks++; if (bus.halted !== r.halted) begin failures++; $display("FAIL branch halted got=%b want=%b", bus.halted, r.halted); end
      @(negedge clk);
    end
  endtask

  task automatic test_indirect();
    rec_t r; ctl_t e1, e2;
    e1 = '0; e1.mem_r_addr_sel = 2'd1; e1.temp_ld = 1'b1;
    e2 = '0; e2.mem_r_addr_sel = 2'd3; e2.rf_w_en = 1'b1; e2.rf_w_data_sel = 2'd1;
    push_instr(16'hA402, 16'h0000, e1, e2, 1'b1, 1'b1);
    e2 = '0; e2.mem_w_en = 1'b1; e2.mem_w_addr_sel = 2'd2; e2.rf_r1_addr_sel = 1'b1;
    push_instr(16'hB402, 16'h8000, e1, e2, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      r = sb.pop_front(); bus.ir = r.ir; bus.cc_data = r.cc; #1;
      checks++; if (bus.state_dbg !== r.state) begin failures++; $display("FAIL indirect state ir=%h got=%0d want=%0d", r.ir, bus.state_dbg, r.state); end
      checks++; if (obs_ctl !== r.ctl) begin failures++; $display("FAIL indirect ctl ir=%h st=%0d got=%h want=%h", r.ir, r.state, obs_ctl, r.ctl); end
      checks++; if (bus.nzp !== r.nzp) begin failures++; $display("FAIL indirect nzp ir=%h got=%b want=%b", r.ir, bus.nzp, r.nzp); end
      checks++; if (bus.halted !== r.halted) begin failures++; $display("FAIL indirect halted got=%b want=%b", bus.halted, r.halted); end
      @(negedge clk);
    end
  endtask

  task automatic test_jump();
    rec_t r; ctl_t e;
    e = '0; e.rf_w_en = 1'b1; e.rf_w_addr_sel = 1'b1; e.rf_w_data_sel = 2'd2;
    e.pc_ld = 1'b1; e.pc_ld_data_sel = 2'd2;
    push_instr(16'h4803, 16'h8000, e, '0, 1'b0, 1'b0);
    e.pc_ld_data_sel = 2'd1;
    push_instr(16'h41C0, 16'h0001, e, '0, 1'b0, 1'b0);
    e = '0; e.pc_ld = 1'b1; e.pc_ld_data_sel = 2'd1;
    push_instr(16'hC1C0, 16'h8000, e, '0, 1'b0, 1'b0);
    push_instr(16'hD000, 16'h8000, '0, '0, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      r = sb.pop_front(); bus.ir = r.ir; bus.cc_data = r.cc; #1;
      checks++; if (bus.state_dbg !== r.state) begin failures++; $display("FAIL jump state ir=%h got=%0d want=%0d", r.ir, bus.state_dbg, r.state); end
      checks++; if (obs_ctl !== r.ctl) begin failures++; $display("FAIL jump ctl ir=%h st=%0d got=%h want=%h", r.ir, r.state, obs_ctl, r.ctl); end
      checks++; if (bus.nzp !== r.nzp) begin failures++; $display("FAIL jump nzp ir=%h got=%b want=%b", r.ir, bus.nzp, r.nzp); end
      checks++; if (bus.halted !== r.halted) begin failures++; $display("FAIL jump halted got=%b want=%b", bus.halted, r.halted); end
      @(negedge clk);
    end
  endtask

  // Reset raised during an ADD's EXEC must drop the pending nzp write.
  task automatic test_abort();
    rec_t r;
    push_rec(16'h1261, 16'h8000, 3'd1, fetch_c(), 1'b0);
    push_rec(16'h1261, 16'h8000, 3'd2, '0, 1'b0);
    push_rec(16'h1261, 16'h8000, 3'd3, '0, 1'b0);
    sb[2].ctl.rf_w_en = 1'b1; sb[2].ctl.alu_imm = 1'b1;
    while (sb.size() > 0) begin
      r = sb.pop_front(); bus.ir = r.ir; bus.cc_data = r.cc; #1;
      checks++; if (bus.state_dbg !== r.state) begin failures++; $display("FAIL abort state got=%0d want=%0d", bus.state_dbg, r.state); end
      checks++; if (obs_ctl !== r.ctl) begin failures++; $display("FAIL abort ctl st=%0d got=%h want=%h", r.state, obs_ctl, r.ctl); end
      checks++; if (bus.nzp !== r.nzp) begin failures++; $display("FAIL abort nzp got=%b want=%b", bus.nzp, r.nzp); end
      if (sb.size() > 0) @(negedge clk);
    end
    rst = 1'b1; #1;
    checks++; if (bus.state_dbg !== 3'd0) begin failures++; $display("FAIL abort_async_state got=%0d want=0", bus.state_dbg); end
    checks++; if (obs_ctl !== init_c()) begin failures++; $display("FAIL abort_async_ctl got=%h want=%h", obs_ctl, init_c()); end
    @(posedge clk); #1;
    exp_nzp = 3'b010;
    checks++; if (bus.nzp !== exp_nzp) begin failures++; $display("FAIL abort_nzp got=%b want=%b", bus.nzp, exp_nzp); end
    @(negedge clk);
    rst = 1'b0;
    push_rec(16'h8000, 16'h0000, 3'd0, init_c(), 1'b0);
    push_instr(16'h8000, 16'h0000, '0, '0, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      r = sb.pop_front(); bus.ir = r.ir; bus.cc_data = r.cc; #1;
      checks++; if (bus.state_dbg !== r.state) begin failures++; $display("FAIL abort_restart state got=%0d want=%0d", bus.state_dbg, r.state); end
      checks++; if (obs_ctl !== r.ctl) begin failures++; $display("FAIL abort_restart ctl got=%h want=%h", obs_ctl, r.ctl); end
      @(negedge clk);
    end
  endtask

  task automatic test_halt();
    rec_t r; ctl_t e;
    e = '0; e.rf_w_en = 1'b1; e.alu_imm = 1'b1;
    push_instr(16'h1261, 16'h0001, e, '0, 1'b0, 1'b1);
    push_rec(16'hF025, 16'h0000, 3'd1, fetch_c(), 1'b0);
    push_rec(16'hF025, 16'h0000, 3'd2, '0, 1'b0);
    for (int k = 0; k < 6; k++) push_rec(16'hF025, 16'h0000, 3'd5, '0, 1'b1);
    while (sb.size() > 0) begin
      r = sb.pop_front(); bus.ir = r.ir; bus.cc_data = r.cc; #1;
      checks++; if (bus.state_dbg !== r.state) begin failures++; $display("FAIL halt state ir=%h got=%0d want=%0d", r.ir, bus.state_dbg, r.state); end
      checks++; if (obs_ctl !== r.ctl) begin failures++; $display("FAIL halt ctl st=%0d got=%h want=%h", r.state, obs_ctl, r.ctl); end
      checks++; if (bus.nzp !== r.nzp) begin failures++; $display("FAIL halt nzp got=%b want=%b", bus.nzp, r.nzp); end
      checks++; if (bus.halted !== r.halted) begin failures++; $display("FAIL halt halted st=%0d got=%b want=%b", r.state, bus.halted, r.halted); end
      @(negedge clk);
    end
    #2 rst = 1'b1; #1;
    exp_nzp = 3'b010;
    checks++; if (bus.state_dbg !== 3'd0) begin failures++; $display("FAIL halt_rst state got=%0d want=0", bus.state_dbg); end
    checks++; if (bus.halted !== 1'b0) begin failures++; $display("FAIL halt_rst halted got=%b want=0", bus.halted); end
    checks++; if (bus.nzp !== exp_nzp) begin failures++; $display("FAIL halt_rst nzp got=%b want=%b", bus.nzp, exp_nzp); end
    checks++; if (obs_ctl !== init_c()) begin failures++; $display("FAIL halt_rst ctl got=%h want=%h", obs_ctl, init_c()); end
    @(negedge clk);
    rst = 1'b0;
    push_rec(16'h8000, 16'h0000, 3'd0, init_c(), 1'b0);
    push_instr(16'h8000, 16'h0000, '0, '0, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      r = sb.pop_front(); bus.ir = r.ir; bus.cc_data = r.cc; #1;
      checks++; if (bus.state_dbg !== r.state) begin failures++; $display("FAIL halt_restart state got=%0d want=%0d", bus.state_dbg, r.state); end
      checks++; if (bus.halted !== r.halted) begin failures++; $display("FAIL halt_restart halted got=%b want=%b", bus.halted, r.halted); end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.ir = 16'h8000;
    bus.cc_data = 16'h0000;
    exp_nzp = 3'b010;
    repeat (2) @(negedge clk);
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_indirect();
    test_jump();
    test_abort();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/punc_control.md
# punc_control

Control unit for the PUnC LC3 processor. It sits beside the PUnC datapath, which holds the PC, IR, temp register, memory, register file and ALU. Every cycle it decodes its state and the IR opcode into the datapath's control strobes and mux selects. It also owns the N/Z/P condition-code register that conditional branches use.

## Interface
Parameters: none; opcode and select encodings are fixed below.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- ir  in  16  current instruction register from datapath
- cc_data  in  16  datapath register-file write data, sampled for condition codes
- mem_w_en  out  1  memory write strobe
- mem_r_addr_sel  out  2  0 PC, 1 PC+sext9, 2 r0_data+sext6, 3 temp
- mem_w_addr_sel  out  2  0 PC+sext9, 1 r0_data+sext6, 2 temp; write data is always r1_data
- temp_ld  out  1  load datapath temp register from mem_r_data
- rf_w_en  out  1  register-file write strobe
- rf_w_addr_sel  out  1  0 ir[11:9], 1 R7
- rf_w_data_sel  out  2  0 ALU, 1 mem_r_data, 2 PC, 3 PC+sext9
- rf_r0_addr_sel  out  1  0 ir[8:6], 1 ir[11:9]
- rf_r1_addr_sel  out  1  0 ir[2:0], 1 ir[11:9]
- alu_sel  out  2  0 ADD, 1 AND, 2 NOT(r0), 3 PASS(r0)
- alu_imm  out  1  ALU B operand = sext(ir[4:0]) instead of r1_data
- ir_ld  out  1  IR <= mem_r_data
- pc_ld, pc_inc, pc_clr  out  1 each  PC load / +1 / clear; priority in datapath is clr > ld > inc
- pc_ld_data_sel  out  2  0 PC+sext9, 1 r0_data, 2 PC+sext11
- nzp  out  3  condition-code register {N,Z,P}
- halted  out  1  high while in HALT
- state_dbg  out  3  current state encoding

## Operation
- State encodings: INIT=0, FETCH=1, DECODE=2, EXEC=3, EXEC2=4, HALT=5.
- Outputs are combinational from state and ir. Any control not listed for a state/opcode is 0.
- INIT: pc_clr=1. Next state: FETCH.
- FETCH: mem_r_addr_sel=0, ir_ld=1, pc_inc=1. Next state: DECODE.
- DECODE: no strobes; IR is now stable. Next state: EXEC, or HALT if opcode=1111.
- EXEC, by ir[15:12]. The PC seen here is already incremented.
  - ADD 0001 / AND 0101: rf_w_en, rf_w_data_sel=0, alu_sel=0 or 1, alu_imm=ir[5].
  - NOT 1001: rf_w_en, alu_sel=2.
  - LD 0010: mem_r_addr_sel=1, rf_w_en, rf_w_data_sel=1.
  - LDR 0110: mem_r_addr_sel=2, rf_w_en, rf_w_data_sel=1.
  - LEA 1110: rf_w_en, rf_w_data_sel=3.
  - ST 0011: mem_w_en, mem_w_addr_sel=0, rf_r1_addr_sel=1.
  - STR 0111: mem_w_en, mem_w_addr_sel=1, rf_r1_addr_sel=1.
  - LDI 1010 / STI 1011: mem_r_addr_sel=1, temp_ld. Next state: EXEC2.
  - BR 0000: if (ir[11:9] & nzp) != 0 then pc_ld, pc_ld_data_sel=0. Mask 000 is never taken.
  - JMP/RET 1100: pc_ld, pc_ld_data_sel=1.
  - JSR/JSRR 0100: rf_w_en, rf_w_addr_sel=1, rf_w_data_sel=2, pc_ld, pc_ld_data_sel = ir[11] ? 2 : 1.
    - R7 and PC both take the pre-edge PC. JSRR R7 jumps to the old R7.
  - 1000 and 1101: NOP.
  - Next state: FETCH, except LDI/STI.
- EXEC2:
  - LDI: mem_r_addr_sel=3, rf_w_en, rf_w_data_sel=1.
  - STI: mem_w_en, mem_w_addr_sel=2, rf_r1_addr_sel=1.
  - Next state: FETCH.
- HALT: absorbing until rst; no strobes; halted=1.
- Condition codes:
  - Update on the clock edge of any EXEC/EXEC2 cycle where rf_w_en=1 and the opcode is ADD, AND, NOT, LD, LDR, LDI or LEA.
  - N=cc_data[15]; Z=(cc_data==0); P=otherwise. Exactly one bit is set.
  - JSR writes do not update nzp.

## Timing
- Reset (asynchronous, immediate): state=INIT, nzp=010. Outputs immediately: pc_clr=1, halted=0, state_dbg=0, all other outputs 0.
- First FETCH is the 2nd rising edge after rst deasserts (INIT occupies one cycle).
- Latency: 3 cycles per instruction; LDI/STI take 4. Register, memory and PC writes commit on the EXEC/EXEC2 exit edge.
- BR evaluates the nzp value from before the EXEC edge. A CC update and a branch never occur in the same cycle.
- rst asserted mid-instruction aborts it. An in-flight write does not commit if rst rises before the edge.

## Test plan
- Reset, then release: INIT holds pc_clr=1 with nzp=010; state_dbg runs 0→1→2→3→1.
- ir=0x1261 (ADD R1,R1,#1), cc_data=0x0001: EXEC shows rf_w_en=1, alu_sel=0, alu_imm=1; nzp becomes 001.
- AND with cc_data=0x8000 then BRn (ir=0x0805): nzp=100; BR EXEC asserts pc_ld with sel=0. Same test with nzp=001: no pc_ld.
- ir=0xA402 (LDI): EXEC asserts temp_ld, mem_r_addr_sel=1; EXEC2 asserts rf_w_en, mem_r_addr_sel=3; 4 cycles total.
- ir=0x4803 (JSR): one EXEC cycle has rf_w_en, rf_w_addr_sel=1, rf_w_data_sel=2, pc_ld, pc_ld_data_sel=2; nzp unchanged.
- ir=0xF025 (HALT): halted=1 from the cycle after DECODE and stays high indefinitely. Pulsing rst mid-HALT returns to INIT asynchronously.
